// File: rtl/vga_bitplane_ram.sv
// Bit-plane memory for the VGA path: masked CPU write, async CPU read,
// registered VGA read and a whole-plane fill sequencer.
`timescale 1ns/1ps
module vga_bitplane_ram #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] wmask,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q,
  input  logic [ADDR_W-1:0] vaddr,
  output logic [DATA_W-1:0] vq,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StFill} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] vq_q;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Fill owns the write port; CPU writes outside IDLE are dropped, and nothing
  // is written on a reset edge so rst never disturbs stored contents.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = (mem[waddr] & ~wmask) | (wd & wmask);
    if (!rst) begin
      if (state_q == StFill) begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = fill_q;
      end else if (we) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d = StFill;
          cnt_d   = '0;
          fill_d  = fill_val;
        end
      end
      StFill: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      vq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      vq_q    <= mem[vaddr];
    end
  end

  // Fill value is only consulted in FILL, so it needs no reset.
  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  assign q    = mem[raddr];
  assign vq   = vq_q;
  assign busy = (state_q == StFill);
  assign done = done_q;

endmodule

// File: tb/tb_vga_bitplane_ram.sv
// Scoreboard bench for vga_bitplane_ram (DATA_W=8, ADDR_W=4): stimulus queues
// expectations, a negedge monitor pops and compares as results appear.
`timescale 1ns/1ps
module tb_vga_bitplane_ram;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wd;
  logic [DW-1:0] wmask;
  logic [AW-1:0] raddr;
  logic [DW-1:0] q;
  logic [AW-1:0] vaddr;
  logic [DW-1:0] vq;
  logic          fill_start;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;

  vga_bitplane_ram #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wd        (wd),
    .wmask     (wmask),
    .raddr     (raddr),
    .q         (q),
    .vaddr     (vaddr),
    .vq        (vq),
    .fill_start(fill_start),
    .fill_val  (fill_val),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    a;
    int    b;
  } exp_t;

  exp_t q_exp[$];
  exp_t vq_exp[$];
  exp_t st_exp[$];
  exp_t fill_exp[$];

  logic q_req = 1'b0;
  logic vq_req = 1'b0;
  logic st_req = 1'b0;
  logic fill_chk = 1'b0;
  logic vq_vld = 1'b0;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  exp_t e;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic underflow(input string which);
    checks++;
    errors++;
    $display("FAIL %s: output with no expectation queued (got 1 expected 0)", which);
  endtask

  // vq has one cycle of latency, so its valid tag is the request delayed.
  always @(posedge clk) vq_vld <= vq_req;

  always @(negedge clk) begin
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    if (q_req) begin
      if (q_exp.size() == 0) underflow("q");
      else begin e = q_exp.pop_front(); cmp(e.name, int'(q), e.a); end
    end
    if (vq_vld) begin
      if (vq_exp.size() == 0) underflow("vq");
      else begin e = vq_exp.pop_front(); cmp(e.name, int'(vq), e.a); end
    end
    if (st_req) begin
      if (st_exp.size() == 0) underflow("status");
      else begin
        e = st_exp.pop_front();
        cmp({e.name, " busy"}, int'(busy), e.a);
        cmp({e.name, " done"}, int'(done), e.b);
      end
    end
    if (fill_chk) begin
      if (fill_exp.size() == 0) underflow("fill");
      else begin
        e = fill_exp.pop_front();
        cmp({e.name, " busy cycles"}, busy_cnt, e.a);
        cmp({e.name, " done pulses"}, done_cnt, e.b);
      end
      busy_cnt = 0;
      done_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    we = 1'b1; waddr = a; wd = d; wmask = m;
    tick();
    we = 1'b0;
  endtask

  task automatic check_q(input logic [AW-1:0] a, input int exp, input string name);
    raddr = a;
    q_exp.push_back('{name: name, a: exp, b: 0});
    q_req = 1'b1;
    tick();
    q_req = 1'b0;
  endtask

  task automatic read_v(input logic [AW-1:0] a, input int exp, input string name);
    vaddr = a;
    vq_exp.push_back('{name: name, a: exp, b: 0});
    vq_req = 1'b1;
    tick();
    vq_req = 1'b0;
  endtask

  task automatic check_st(input int b, input int d, input string name);
    st_exp.push_back('{name: name, a: b, b: d});
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
  endtask

  task automatic check_fill(input int b, input int d, input string name);
    fill_exp.push_back('{name: name, a: b, b: d});
    fill_chk = 1'b1;
    tick();
    fill_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running (got timeout expected finish)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wd = '0; wmask = '0; raddr = '0;
    vaddr = '0; fill_start = 1'b0; fill_val = '0;
    tick_n(2);
    check_st(0, 0, "reset status");
    read_v(0, 0, "reset vq");
    check_q(0, 0, "powerup q[0]");
    check_q(15, 0, "powerup q[15]");
    rst = 1'b0;
    tick();

    // Basic write, neighbours untouched
    write(5, 8'h01, 8'hFF);
    check_q(5, 8'h01, "basic q[5]");
    check_q(4, 8'h00, "basic q[4]");
    check_q(6, 8'h00, "basic q[6]");
    read_v(5, 8'h01, "basic vq[5]");

    // Masked write: F0 -> (F0 & ~3C) | (0F & 3C) = CC
    write(3, 8'hF0, 8'hFF);
    write(3, 8'h0F, 8'h3C);
    check_q(3, 8'hCC, "masked q[3]");
    write(3, 8'h00, 8'h00);
    check_q(3, 8'hCC, "zero mask no-op");

    // Read-old: vq sees the pre-write value on the writing edge
    we = 1'b1; waddr = 2; wd = 8'h01; wmask = 8'hFF;
    vaddr = 2;
    vq_exp.push_back('{name: "read-old first", a: 8'h00, b: 0});
    vq_req = 1'b1;
    tick();
    we = 1'b0;
    vq_exp.push_back('{name: "read-old second", a: 8'h01, b: 0});
    tick();
    vq_req = 1'b0;

    // Full fill with A5; a late write to 7 and fill_start/fill_val changes are ignored
    fill_val = 8'hA5; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    check_st(1, 0, "fill busy first");
    tick_n(9);
    we = 1'b1; waddr = 7; wd = 8'h00; wmask = 8'hFF;
    fill_start = 1'b1; fill_val = 8'h11;
    tick();
    we = 1'b0; fill_start = 1'b0;
    tick_n(4);
    check_st(1, 0, "fill busy last");
    check_st(0, 1, "fill done pulse");
    check_st(0, 0, "fill done clears");
    check_fill(16, 1, "fill A5");
    for (int i = 0; i < 16; i++) check_q(AW'(i), 8'hA5, $sformatf("fill q[%0d]", i));
    read_v(7, 8'hA5, "fill vq[7]");
    read_v(15, 8'hA5, "fill vq[15]");

    // Reset after 6 fill writes: busy seen for 7 cycles (incl. the rst cycle), no done
    fill_val = 8'h01; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick_n(6);
    rst = 1'b1;
    read_v(6, 8'h00, "vq cleared by rst");
    rst = 1'b0;
    check_st(0, 0, "rst aborts fill");
    check_fill(7, 0, "aborted fill");
    for (int i = 0; i < 16; i++)
      check_q(AW'(i), (i < 6) ? 8'h01 : 8'hA5, $sformatf("abort q[%0d]", i));
    read_v(0, 8'h01, "vq after abort");

    // Write accepted alongside fill_start, then overwritten by the fill
    we = 1'b1; waddr = 9; wd = 8'h01; wmask = 8'hFF;
    fill_start = 1'b1; fill_val = 8'h00;
    tick();
    we = 1'b0; fill_start = 1'b0;
    check_q(9, 8'h01, "write beside fill_start");
    tick_n(15);
    check_st(0, 1, "zero fill done");
    check_fill(16, 1, "zero fill");
    check_q(9, 8'h00, "q[9] overwritten");
    check_q(0, 8'h00, "zero fill q[0]");
    check_q(15, 8'h00, "zero fill q[15]");

    tick_n(3);
    checks++;
    if (q_exp.size() + vq_exp.size() + st_exp.size() + fill_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0",
               q_exp.size() + vq_exp.size() + st_exp.size() + fill_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_bitplane_ram.md
Name: vga_bitplane_ram

Overview:
Parametrised bit-plane memory for the VGA/tetris display path. It generalises the 16x1 single-port RAM to DATA_W x 2**ADDR_W storage. It provides:
- a masked write port
- an asynchronous CPU-side read port
- a registered VGA-side read port
- a hardware fill sequencer that clears or paints the whole plane without CPU writes

It sits between the CPU store path and the VGA scan logic.

Parameters:
DATA_W, 1, bits per word
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (derived, not overridable)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
we  in  1  write enable, CPU port
waddr  in  ADDR_W  write address
wd  in  DATA_W  write data
wmask  in  DATA_W  per-bit write enable; bit i=1 updates bit i
raddr  in  ADDR_W  CPU read address
q  out  DATA_W  CPU read data, combinational = mem[raddr]
vaddr  in  ADDR_W  VGA read address
vq  out  DATA_W  VGA read data, registered, 1-cycle latency
fill_start  in  1  request whole-plane fill
fill_val  in  DATA_W  fill value, sampled with fill_start
busy  out  1  fill in progress
done  out  1  one-cycle pulse after fill completes

Behaviour:
- Reset (rst=1 at rising edge):
  - State goes to IDLE; fill counter = 0.
  - busy=0, done=0, vq=0.
  - Memory contents are NOT altered by rst. Power-up contents are all-zero (initial block).
- CPU write, IDLE only:
  - If we=1: mem[waddr] <= (mem[waddr] & ~wmask) | (wd & wmask).
  - wmask=0 is a no-op.
- q is purely combinational. A write becomes visible on q immediately after the writing edge.
- vq <= mem[vaddr] every cycle, including during a fill. Read-old semantics: if vaddr matches the address being written that edge, vq gets the pre-write value.
- FSM states: IDLE, FILL.
  - IDLE -> FILL: fill_start=1 at an edge. Latch fill_val into fill_reg; cnt=0.
    - A CPU write presented in that same cycle is still performed at that edge.
  - FILL, each cycle: mem[cnt] <= fill_reg (full word, wmask ignored); cnt <= cnt+1.
  - FILL -> IDLE: at the edge writing cnt=DEPTH-1. done=1 for the following cycle only.
  - busy=1 exactly while state=FILL, i.e. DEPTH cycles, starting the cycle after fill_start is accepted.
- Fill duration: DEPTH cycles busy. done is asserted in cycle DEPTH+1 after acceptance.
- During FILL:
  - we is ignored and the write is dropped (no queueing).
  - fill_start is ignored.
  - A new fill_val has no effect.
- Back-to-back fills: fill_start held high in the done cycle (state IDLE) starts a new fill. done and the new busy rise together.
- Counter is ADDR_W bits and wraps naturally. The end condition is cnt==DEPTH-1, not overflow.
- rst mid-fill: aborts immediately. busy=0, no done pulse. Words already filled keep fill_reg; the rest are unchanged.
- DATA_W=1, ADDR_W=4 must be behaviourally identical to the 16x1 RAM when fill_start=0 and wmask=1. The only addition is the vq port.

Test Plan:
- Basic write/read, defaults: we=1, waddr=5, wd=1, wmask=1 -> q at raddr=5 reads 1 after edge. vaddr=5 gives vq=1 one cycle later. Other addresses stay 0.
- Masked write, DATA_W=8: mem[3]=8'hF0, then write wd=8'h0F, wmask=8'h3C -> mem[3]=8'hCC.
- Fill, DATA_W=8, ADDR_W=4: pulse fill_start with fill_val=8'hA5 -> busy high exactly 16 cycles, done pulses once. All 16 addresses read 8'hA5. we=1 to addr 7 mid-fill is dropped; addr 7 stays 8'hA5.
- Read-old: write addr 2 from 0 to 1 with vaddr=2 in the same cycle -> vq=0 the next cycle, vq=1 the cycle after.
- Reset mid-fill: after 6 fill cycles with fill_val=1, assert rst -> busy=0 next cycle, no done. Addrs 0-5 = 1, addrs 6-15 keep their prior values. vq=0 after reset.
- Fill_start with a simultaneous write in IDLE: we to addr 9 with wd=1, fill_val=0 -> write lands, then the fill overwrites it. Final mem[9]=0, done after 16 busy cycles.
